// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default pointer sizing and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int DEF_ADDRSIZE = 4;
    localparam int MAX_PTR_W    = 32;

    function automatic int fifo_depth(input int addrsize);
        return 2 ** addrsize;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin_to_gray(input logic [MAX_PTR_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero-extended inputs convert correctly: the leading zero bits stay zero.
    function automatic logic [MAX_PTR_W-1:0] gray_to_bin(input logic [MAX_PTR_W-1:0] gray);
        logic [MAX_PTR_W-1:0] bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterized Gray-to-binary converter, purely combinational.
module gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_ADDRSIZE + 1
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray_to_bin(MAX_PTR_W'(gray)));

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-side pointer, full/almost-full and fill-level logic of an async FIFO.
// Optional sticky overflow flag enabled by defining WPTR_FULL_OVF_EN.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_THRESH = fifo_depth(ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wen,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int              PTR_W   = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] AFULL_W = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] wlevel_q, wlevel_d;
    logic [PTR_W-1:0] rq2_bin;
    logic [PTR_W-1:0] rptr_full_cmp;
    logic             wfull_q, wfull_d;
    logic             wafull_q, wafull_d;
    logic             winc_ok;

    gray2bin #(.WIDTH(PTR_W)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rq2_bin)
    );

    assign winc_ok = winc & ~wfull_q;

    // Full when the next write pointer sits exactly one lap ahead of the read pointer.
    assign rptr_full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        wbin_d   = wbin_q + PTR_W'(winc_ok);
        wptr_d   = PTR_W'(bin_to_gray(MAX_PTR_W'(wbin_d)));
        wfull_d  = (wptr_d == rptr_full_cmp);
        wlevel_d = wbin_d - rq2_bin;
        wafull_d = (wlevel_d >= AFULL_W);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        // NOTE: every state flop, including the counter, is cleared by the async reset
        // so in-flight writes are abandoned and the next accepted write lands at address 0.
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample the pre-edge values together.
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
        end
    end

    assign wptr   = wptr_q;
    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wen    = winc_ok;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;

`ifdef WPTR_FULL_OVF_EN
    logic woverflow_q, woverflow_d;

    always_comb begin
        // NOTE: default first so no path leaves woverflow_d unassigned (no latch).
        woverflow_d = woverflow_q;
        if (winc & wfull_q) begin
            woverflow_d = 1'b1;
        end else if (wovf_clr) begin
            woverflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow_q <= 1'b0;
        end else begin
            woverflow_q <= woverflow_d;
        end
    end

    assign woverflow = woverflow_q;
`else
    logic ovf_clr_unused;

    assign ovf_clr_unused = wovf_clr;
    assign woverflow      = 1'b0;
`endif

endmodule
